// File: rtl/afifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// Both the write-side and the read-side controllers take their pointer
// width, depth and Gray/binary helpers from here so the two domains agree.
package afifo_pkg;

  // The pointer carries one extra wrap bit above the RAM address.
  function automatic int ptr_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

  // Number of RAM words addressed by addr_w bits.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Binary to reflected Gray. Zero-extended operands convert correctly,
  // so callers may pass any width up to 32 bits and keep the low bits.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or
  // above it. Zero-extension leaves the low bits unchanged.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_ctrl_if.sv
// Write-side FIFO bundle: client request, RAM write port, synchronised read
// pointer and status flags. The master is the client/system side, the slave
// is the write pointer controller.
interface wr_ptr_ctrl_if
  import afifo_pkg::*;
#(
  parameter int ADDR_W = 4
);
  localparam int PTR_W = ptr_w_of(ADDR_W);

  logic              wr_en;
  logic [PTR_W-1:0]  g_rd_ptr_sync;
  logic [PTR_W-1:0]  af_level;
  logic              ovf_clr;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [PTR_W-1:0]  g_wr_ptr;
  logic              full;
  logic              almost_full;
  logic [PTR_W-1:0]  wr_count;
  logic              overflow;

  modport master (
    output wr_en, g_rd_ptr_sync, af_level, ovf_clr,
    input  wr_fire, wr_addr, g_wr_ptr, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  wr_en, g_rd_ptr_sync, af_level, ovf_clr,
    output wr_fire, wr_addr, g_wr_ptr, full, almost_full, wr_count, overflow
  );

endinterface

// File: rtl/wr_ptr_ctrl_gray2bin.sv
// Purely combinational Gray-to-binary decoder of configurable width.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // Binary bit i is the parity of Gray bits W-1 down to i.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer controller for the dual-clock FIFO. Tracks the binary
// and Gray write pointers, the write-side occupancy, full / almost-full and
// a sticky overflow flag, and drives the RAM write strobe and address.
// Full and occupancy are computed against the synchronised (lagging) read
// pointer, so they can only be pessimistic, never optimistic.
module wr_ptr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic         wr_clk,
  input  logic         rst_n,
  wr_ptr_ctrl_if.slave bus
);

  localparam int PTR_W = ptr_w_of(ADDR_W);

  // Registered state
  logic [PTR_W-1:0] b_wr_ptr;
  logic [PTR_W-1:0] g_wr_ptr_r;
  logic [PTR_W-1:0] wr_count_r;
  logic             full_r;
  logic             almost_full_r;
  logic             overflow_r;

  // Next-state terms
  logic             wr_fire;
  logic [PTR_W-1:0] b_next;
  logic [PTR_W-1:0] g_next;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] cnt_next;
  logic [PTR_W-1:0] g_rd_full;
  logic             full_next;
  logic             af_next;
  logic             ovf_next;

  gray2bin #(
    .W (PTR_W)
  ) u_rd_g2b (
    .g (bus.g_rd_ptr_sync),
    .b (rd_bin)
  );

  // A request is only honoured out of reset and with room left; a refused
  // write leaves the pointers alone and never reaches the RAM.
  assign wr_fire = bus.wr_en & ~full_r & rst_n;

  // Pointer advance and occupancy; modulo arithmetic covers the wrap.
  always_comb begin
    b_next   = b_wr_ptr + PTR_W'(wr_fire);
    g_next   = b_next ^ (b_next >> 1);
    cnt_next = b_next - rd_bin;
  end

  // Full when the next Gray write pointer equals the read pointer with its
  // two top bits inverted (same address, opposite lap).
  always_comb begin
    g_rd_full = {~bus.g_rd_ptr_sync[PTR_W-1:PTR_W-2], bus.g_rd_ptr_sync[PTR_W-3:0]};
    full_next = (g_next == g_rd_full);
  end

  // Unsigned threshold compare: level 0 always asserts, levels above the
  // depth can never be reached by the count.
  always_comb begin
    af_next = (cnt_next >= bus.af_level);
  end

  // Sticky overflow: a refused request sets it, clear only acts when no
  // set is present in the same cycle.
  always_comb begin
    ovf_next = overflow_r;
    if (bus.wr_en && full_r) begin
      ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // All write-domain state, cleared together by the synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      b_wr_ptr      <= '0;
      g_wr_ptr_r    <= '0;
      wr_count_r    <= '0;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      b_wr_ptr      <= b_next;
      g_wr_ptr_r    <= g_next;
      wr_count_r    <= cnt_next;
      full_r        <= full_next;
      almost_full_r <= af_next;
      overflow_r    <= ovf_next;
    end
  end

  // The Gray pointer leaves straight from its flop so the crossing sees a
  // single-bit, glitch-free change per accepted write.
  assign bus.wr_fire     = wr_fire;
  assign bus.wr_addr     = b_wr_ptr[ADDR_W-1:0];
  assign bus.g_wr_ptr    = g_wr_ptr_r;
  assign bus.full        = full_r;
  assign bus.almost_full = almost_full_r;
  assign bus.wr_count    = wr_count_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl with ADDR_W=4. A behavioural model tracks the write
// pointer as a plain integer and the read pointer as the integer the bench
// presents; occupancy, full and almost-full follow from integer arithmetic.
module tb_wr_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int PTR_W  = 5;
  localparam int DEPTH  = 16;

  logic wr_clk = 1'b0;
  logic rst_n;

  always #5 wr_clk = ~wr_clk;

  wr_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  wr_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: values the registered outputs must hold after each edge
  int m_wp    = 0;
  int rp      = 0;
  int m_cnt   = 0;
  bit m_full  = 0;
  bit m_af    = 0;
  bit m_ovf   = 0;
  bit m_fire_last = 0;
  bit started = 0;
  bit wrapped = 0;

  always @(posedge wr_clk) begin
    bit fire;
    fire = bus.wr_en && !m_full && rst_n;
    if (!rst_n) begin
      m_wp  = 0;
      m_cnt = 0;
      m_full = 0;
      m_af  = 0;
      m_ovf = 0;
    end else begin
      if (bus.wr_en && m_full) m_ovf = 1;
      else if (bus.ovf_clr)    m_ovf = 0;
      if (fire) begin
        if (m_wp == 31) wrapped = 1;
        m_wp = (m_wp + 1) % 32;
      end
      m_cnt  = (m_wp - rp + 32) % 32;
      m_full = (m_cnt == DEPTH);
      m_af   = (m_cnt >= int'(bus.af_level));
    end
    m_fire_last = fire;
    started = 1;
  end

  // Compare every output against the model on the falling edge
  logic [PTR_W-1:0] prev_g;
  bit have_prev = 0;

  always @(negedge wr_clk) begin
    if (started) begin
      chk("wr_fire",     32'(bus.wr_fire),     32'(bus.wr_en && !m_full && rst_n));
      chk("wr_addr",     32'(bus.wr_addr),     32'(m_wp % 16));
      chk("g_wr_ptr",    32'(bus.g_wr_ptr),    32'(m_wp ^ (m_wp >> 1)));
      chk("full",        32'(bus.full),        32'(m_full));
      chk("almost_full", 32'(bus.almost_full), 32'(m_af));
      chk("wr_count",    32'(bus.wr_count),    32'(m_cnt));
      chk("overflow",    32'(bus.overflow),    32'(m_ovf));
      chk("cnt_range",   32'(bus.wr_count <= 5'(DEPTH)), 32'd1);
      if (m_fire_last && have_prev)
        chk("gray_step", 32'($countones(bus.g_wr_ptr ^ prev_g)), 32'd1);
      prev_g    = bus.g_wr_ptr;
      have_prev = 1;
    end
  end

  task automatic set_rp(input int v);
    rp = v;
    bus.g_rd_ptr_sync = PTR_W'(v ^ (v >> 1));
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"},  32'(bus.full),        32'd0);
    chk({tag, "_cnt"},   32'(bus.wr_count),    32'd0);
    chk({tag, "_g"},     32'(bus.g_wr_ptr),    32'd0);
    chk({tag, "_af"},    32'(bus.almost_full), 32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow),    32'd0);
    chk({tag, "_addr"},  32'(bus.wr_addr),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int cycles;

    // Reset held for two cycles with a pending write request
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.ovf_clr = 1'b0;
    bus.af_level = 5'd12;
    set_rp(0);
    #1 chk("rst_fire", 32'(bus.wr_fire), 32'd0);
    tick();
    chk_zero("rst1");
    chk("rst_fire1", 32'(bus.wr_fire), 32'd0);
    tick();
    chk_zero("rst2");
    chk("rst_fire2", 32'(bus.wr_fire), 32'd0);

    // Fill: 17 requests, the last one refused
    rst_n = 1'b1;
    #1;
    chk("first_fire", 32'(bus.wr_fire), 32'd1);
    chk("first_addr", 32'(bus.wr_addr), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 11) chk("af_before", 32'(bus.almost_full), 32'd0);
      if (i == 12) chk("af_rise",   32'(bus.almost_full), 32'd1);
      if (i == 15) chk("not_full15", 32'(bus.full), 32'd0);
      if (i == 16) begin
        chk("full16",  32'(bus.full),     32'd1);
        chk("cnt16",   32'(bus.wr_count), 32'd16);
        chk("g16",     32'(bus.g_wr_ptr), 32'b11000);
        chk("ovf16",   32'(bus.overflow), 32'd0);
        #1 chk("drop_fire", 32'(bus.wr_fire), 32'd0);
      end
      if (i == 17) begin
        chk("ovf17", 32'(bus.overflow), 32'd1);
        chk("g17",   32'(bus.g_wr_ptr), 32'b11000);
      end
    end
    bus.wr_en = 1'b0;

    // Release: read pointer advances by one
    set_rp(1);
    tick();
    chk("rel_full", 32'(bus.full),     32'd0);
    chk("rel_cnt",  32'(bus.wr_count), 32'd15);
    bus.wr_en = 1'b1;
    tick();
    chk("refull",   32'(bus.full),     32'd1);
    chk("refull_g", 32'(bus.g_wr_ptr), 32'b11001);
    bus.wr_en = 1'b0;

    // Overflow clear: set wins over clear, then clear alone works
    bus.ovf_clr = 1'b1;
    bus.wr_en = 1'b1;
    tick();
    chk("ovf_hold", 32'(bus.overflow), 32'd1);
    chk("ovf_hold_g", 32'(bus.g_wr_ptr), 32'b11001);
    bus.wr_en = 1'b0;
    tick();
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    bus.ovf_clr = 1'b0;

    // Wrap: random writes interleaved with read advances
    accepted = 0;
    cycles = 0;
    while (accepted < 40 && cycles < 2000) begin
      bus.wr_en = ($urandom_range(0, 3) != 0);
      if (bus.wr_en && !m_full) accepted++;
      if (((m_wp - rp + 32) % 32) > 0 && $urandom_range(0, 1) == 1)
        set_rp((rp + 1) % 32);
      bus.ovf_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        bus.af_level = PTR_W'($urandom_range(0, 20));
      tick();
      cycles++;
    end
    chk("wrap_done", 32'(accepted >= 40), 32'd1);
    chk("wrapped",   32'(wrapped),        32'd1);
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.af_level = 5'd12;

    // Mid-stream reset after five writes
    set_rp(m_wp);
    tick();
    chk("drain_cnt", 32'(bus.wr_count), 32'd0);
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_cnt", 32'(bus.wr_count), 32'd5);
    rst_n = 1'b0;
    set_rp(0);
    #1 chk("mrst_fire", 32'(bus.wr_fire), 32'd0);
    tick();
    chk_zero("mrst");
    rst_n = 1'b1;
    #1;
    chk("post_fire", 32'(bus.wr_fire), 32'd1);
    chk("post_addr", 32'(bus.wr_addr), 32'd0);
    tick();
    chk("post_g",   32'(bus.g_wr_ptr), 32'd1);
    chk("post_cnt", 32'(bus.wr_count), 32'd1);
    bus.wr_en = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
